// File: rtl/shift_reg_ctrl.sv
// Purpose: sequencing controller for a universal shift register: load a word, shift it N places, capture the result.
// Latency: accept at edge 0 -> result at edge min(n_shift,WIDTH)+2, done pulse in the following cycle.
// Backpressure: ready is high only in IDLE; start while not ready is dropped, never queued.
module shift_reg_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic             dir,
    input  logic             fill,
    input  logic [CW-1:0]    n_shift,
    input  logic [WIDTH-1:0] data,
    input  logic             abort,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] reg_pdin,
    output logic             reg_sl_din,
    output logic             reg_sr_din,
    input  logic [WIDTH-1:0] reg_q,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]    SEL_HOLD  = 2'd0;
    localparam logic [1:0]    SEL_RIGHT = 2'd1;
    localparam logic [1:0]    SEL_LEFT  = 2'd2;
    localparam logic [1:0]    SEL_LOAD  = 2'd3;
    localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       sel_q, sel_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // Next-state and next-output decode; outputs are derived from the state being entered so they stay registered.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dir_d     = dir_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort is meaningless here, so a simultaneous start still wins
                if (start) begin
                    data_d  = data;
                    dir_d   = dir;
                    fill_d  = fill;
                    cnt_d   = (n_shift > CNT_MAX) ? CNT_MAX : n_shift;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // register has settled after the last shift; capture it on the way out
                result_d = reg_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_LOAD:  sel_d = SEL_LOAD;
            ST_SHIFT: sel_d = dir_d ? SEL_LEFT : SEL_RIGHT;
            default:  sel_d = SEL_HOLD;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // FSM state, job latches and registered outputs; reset drops any job in flight without pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            sel_q     <= SEL_HOLD;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            sel_q     <= sel_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign sel        = sel_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign result     = result_q;
    assign reg_pdin   = data_q;
    assign reg_sl_din = fill_q;
    assign reg_sr_din = fill_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl with a 4-bit universal shift register attached.
// A per-cycle expected-output trace is built at each accepted job from the shift rules and compared every cycle.
// Directed jobs add literal expectations for sel sequences, results and pulse behaviour.
module tb_shift_reg_ctrl;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready;
    logic       dir = 1'b0;
    logic       fill = 1'b0;
    logic [2:0] n_shift = '0;
    logic [3:0] data = '0;
    logic       abort = 1'b0;
    logic [1:0] sel;
    logic [3:0] reg_pdin;
    logic       reg_sl_din;
    logic       reg_sr_din;
    logic [3:0] reg_q = '0;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] result;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;

    shift_reg_ctrl #(.WIDTH(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .dir(dir), .fill(fill),
        .n_shift(n_shift), .data(data), .abort(abort), .sel(sel), .reg_pdin(reg_pdin),
        .reg_sl_din(reg_sl_din), .reg_sr_din(reg_sr_din), .reg_q(reg_q), .busy(busy),
        .done(done), .aborted(aborted), .result(result)
    );

    always #5 clk = ~clk;

    // The controlled universal shift register
    always @(posedge clk) begin
        case (sel)
            2'd1: reg_q <= {reg_sr_din, reg_q[3:1]};
            2'd2: reg_q <= {reg_q[2:0], reg_sl_din};
            2'd3: reg_q <= reg_pdin;
            default: reg_q <= reg_q;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: expected per-cycle trace ----------------
    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic       aborted;
        logic [3:0] result;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur = '0;
    logic [3:0] m_result = '0;
    logic [3:0] m_data = '0;
    logic       m_fill = 1'b0;

    function automatic exp_t mk(input logic [1:0] s, input logic b, input logic d,
                                input logic a, input logic [3:0] r);
        exp_t e;
        e.sel = s; e.busy = b; e.done = d; e.aborted = a; e.result = r;
        return e;
    endfunction

    // Word left in a register after k shifts with a constant fill bit
    function automatic logic [3:0] shifted(input logic [3:0] d, input logic left,
                                           input logic f, input int k);
        int v;
        if (left) v = ((int'(d) << k) & 15) | (f ? ((1 << k) - 1) : 0);
        else      v = (int'(d) >> k) | (f ? ((15 << (W - k)) & 15) : 0);
        return v[3:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            cur      = '0;
            m_result = '0;
            m_data   = '0;
            m_fill   = 1'b0;
        end else begin
            if (!cur.busy && start) begin
                int k;
                logic [3:0] r;
                k = (int'(n_shift) > W) ? W : int'(n_shift);
                m_data = data;
                m_fill = fill;
                r = shifted(data, dir, fill, k);
                exp_q.delete();
                exp_q.push_back(mk(2'd3, 1'b1, 1'b0, 1'b0, m_result));
                for (int i = 0; i < k; i++)
                    exp_q.push_back(mk(dir ? 2'd2 : 2'd1, 1'b1, 1'b0, 1'b0, m_result));
                exp_q.push_back(mk(2'd0, 1'b1, 1'b0, 1'b0, m_result));
                exp_q.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, r));
            end else if (cur.busy && cur.sel != 2'd0 && abort) begin
                exp_q.delete();
                exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, m_result));
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = mk(2'd0, 1'b0, 1'b0, 1'b0, m_result);
            if (cur.done) m_result = cur.result;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("sel", 32'(sel), 32'(cur.sel));
            chk("ready", 32'(ready), 32'(!cur.busy));
            chk("busy", 32'(busy), 32'(cur.busy));
            chk("done", 32'(done), 32'(cur.done));
            chk("aborted", 32'(aborted), 32'(cur.aborted));
            chk("result", 32'(result), 32'(cur.result));
            chk("reg_pdin", 32'(reg_pdin), 32'(m_data));
            chk("reg_sl_din", 32'(reg_sl_din), 32'(m_fill));
            chk("reg_sr_din", 32'(reg_sr_din), 32'(m_fill));
            if (done) n_done++;
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] seq_v;
    int          len_v;

    // Call just after a rising edge; returns just after the accepting edge
    task automatic start_job(input logic [3:0] d, input logic dr, input logic f,
                             input logic [2:0] n, input logic ab);
        data = d; dir = dr; fill = f; n_shift = n; start = 1'b1; abort = ab;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    // Records sel for every busy cycle; returns at the negedge of the first idle cycle
    task automatic capture(output logic [31:0] seq, output int len);
        seq = '0;
        len = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            seq = {seq[29:0], sel};
            len++;
        end
    endtask

    task automatic job_checks(input string name, input logic [31:0] exp_seq, input int exp_len,
                              input logic [3:0] exp_res);
        chk({name, "_seq"}, seq_v, exp_seq);
        chk({name, "_len"}, 32'(len_v), 32'(exp_len));
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_result"}, 32'(result), 32'(exp_res));
        chk({name, "_model"}, 32'(m_result), 32'(exp_res));
        @(posedge clk); #1;
        chk({name, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_before;

        // Reset state, checked while reset is still held
        #23;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_pdin", 32'(reg_pdin), 32'd0);
        chk("rst_pulses", 32'({done, aborted}), 32'd0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // right by 2, zero fill: 3,1,1,0
        start_job(4'b1011, 1'b0, 1'b0, 3'd2, 1'b0);
        capture(seq_v, len_v);
        job_checks("r2", 32'hD4, 4, 4'b0010);

        // left by 1, one fill: 3,2,0
        start_job(4'b1011, 1'b1, 1'b1, 3'd1, 1'b0);
        capture(seq_v, len_v);
        job_checks("l1", 32'h38, 3, 4'b0111);

        // zero count: 3,0
        start_job(4'b1011, 1'b0, 1'b0, 3'd0, 1'b0);
        capture(seq_v, len_v);
        job_checks("n0", 32'hC, 2, 4'b1011);

        // saturating count: 7 -> 4 right shifts
        start_job(4'b1011, 1'b0, 1'b1, 3'd7, 1'b0);
        capture(seq_v, len_v);
        job_checks("sat", 32'hD54, 6, 4'b1111);

        // abort in second SHIFT cycle of an n=3 job
        done_before = n_done;
        start_job(4'b0110, 1'b1, 1'b0, 3'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_sel", 32'(sel), 32'd0);
        chk("ab_aborted", 32'(aborted), 32'd1);
        chk("ab_ready", 32'(ready), 32'd1);
        chk("ab_result", 32'(result), 32'hF);
        @(posedge clk); #1;
        chk("ab_aborted_1cyc", 32'(aborted), 32'd0);
        chk("ab_no_done", 32'(n_done - done_before), 32'd0);

        // abort together with start in IDLE: start wins
        start_job(4'b1001, 1'b0, 1'b0, 3'd1, 1'b1);
        capture(seq_v, len_v);
        job_checks("abst", 32'h34, 3, 4'b0100);

        // abort during DONE is ignored
        start_job(4'b0101, 1'b0, 1'b0, 3'd0, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abdone_done", 32'(done), 32'd1);
        chk("abdone_aborted", 32'(aborted), 32'd0);
        chk("abdone_result", 32'(result), 32'h5);
        @(posedge clk); #1;

        // start held while busy is ignored
        done_before = n_done;
        start_job(4'b0011, 1'b1, 1'b0, 3'd2, 1'b0);
        fork
            capture(seq_v, len_v);
            begin
                start = 1'b1; data = 4'b1111; n_shift = 3'd0;
                repeat (3) @(posedge clk);
                #1 start = 1'b0;
            end
        join
        job_checks("busy_start", 32'hE8, 4, 4'b1100);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_start_one_done", 32'(n_done - done_before), 32'd1);
        chk("busy_start_idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of SHIFT
        done_before = n_done;
        start_job(4'b1011, 1'b0, 1'b1, 3'd3, 1'b0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_ready", 32'(ready), 32'd1);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_no_pulse", 32'(n_done - done_before), 32'd0);
        start_job(4'b0110, 1'b0, 1'b0, 3'd1, 1'b0);
        capture(seq_v, len_v);
        job_checks("post_rst", 32'h34, 3, 4'b0011);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, data width of the controlled universal shift register.
REQ-002 Parameter: CW, 3, count width, SHALL satisfy 2^CW > WIDTH.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request; accepted when start=1 and ready=1.
REQ-006 ready  out  1  high only in IDLE.
REQ-007 dir  in  1  0 = shift right (sel=1), 1 = shift left (sel=2); sampled on accept.
REQ-008 fill  in  1  serial fill bit; sampled on accept.
REQ-009 n_shift  in  CW  requested shift count; sampled on accept.
REQ-010 data  in  WIDTH  word to load; sampled on accept.
REQ-011 abort  in  1  synchronous cancel of the current operation.
REQ-012 sel  out  2  register operation: 0 = hold, 1 = right, 2 = left, 3 = parallel load.
REQ-013 reg_pdin  out  WIDTH  parallel word to the register.
REQ-014 reg_sl_din  out  1  left serial input (enters LSB on left shift).
REQ-015 reg_sr_din  out  1  right serial input (enters MSB on right shift).
REQ-016 reg_q  in  WIDTH  register parallel output.
REQ-017 busy  out  1  high in LOAD, SHIFT and DONE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 aborted  out  1  one-cycle abort pulse.
REQ-020 result  out  WIDTH  captured final register value.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, LOAD, SHIFT and DONE.
REQ-022 In IDLE, sel SHALL be 0; on accept, data/dir/fill/min(n_shift,WIDTH) SHALL be latched and the FSM SHALL go to LOAD.
REQ-023 An n_shift value above WIDTH SHALL saturate to WIDTH.
REQ-024 In LOAD, sel SHALL be 3 and reg_pdin SHALL be the latched data for exactly one cycle; next state SHALL be SHIFT if the count is > 0, else DONE.
REQ-025 In SHIFT, sel SHALL be 1 or 2 per the latched dir for exactly count cycles; the remaining count decrements each cycle; on the last cycle next state SHALL be DONE.
REQ-026 reg_sl_din and reg_sr_din SHALL both equal the latched fill in every state.
REQ-027 In DONE, sel SHALL be 0; on the edge leaving DONE, result SHALL capture reg_q and the FSM SHALL return to IDLE.
REQ-028 done SHALL be a registered pulse, high only in the first IDLE cycle after DONE.
REQ-029 Latency: with accept at edge 0, result SHALL update at edge count+2 and done SHALL be high during the cycle after that edge.
REQ-030 start while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-031 abort=1 in LOAD or SHIFT SHALL force IDLE at the next edge: sel=0 from that edge, aborted high for one cycle, done not asserted, result unchanged.
REQ-032 abort in IDLE or DONE SHALL be ignored; DONE SHALL complete normally.
REQ-033 abort and start in the same IDLE cycle: start SHALL be accepted.
REQ-034 reg_pdin SHALL equal the latched data in all states.

Reset
REQ-035 rst=1 SHALL immediately, regardless of clk, force IDLE and set sel=0, reg_pdin=0, fill latch=0, count=0, result=0, done=0, aborted=0, busy=0, ready=1.
REQ-036 Reset asserted mid-operation SHALL discard the operation with no done or aborted pulse.

Verification (WIDTH=4, controller wired to a 4-bit universal shift register)
REQ-037 data=1011, dir=0, fill=0, n_shift=2 -> sel sequence 3,1,1,0; result=0010 at edge 4; done pulse in the following cycle.
REQ-038 data=1011, dir=1, fill=1, n_shift=1 -> sel 3,2,0; result=0111; done one cycle.
REQ-039 data=1011, n_shift=0 -> sel 3,0; result=1011 at edge 2; n_shift=7, dir=0, fill=1 -> exactly 4 right shifts, result=1111.
REQ-040 abort in 2nd SHIFT cycle of an n=3 job -> next cycle sel=0, aborted=1 for one cycle, done stays 0, result keeps its prior value, ready=1.
REQ-041 start pulsed while busy -> no effect; the job finishes as specified; only one done pulse.
REQ-042 rst asserted between clock edges during SHIFT -> sel=0, busy=0, result=0 without waiting for clk; a new job after release runs normally.
